// File: rtl/pong_pkg.sv
// Shared encodings and playfield constants for the pong paddle controllers.
package pong_pkg;

  typedef enum logic [1:0] {
    MODE_SWEEP   = 2'd0,
    MODE_FOLLOW  = 2'd1,
    MODE_PREDICT = 2'd2,
    MODE_HOLD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_WAIT_NET = 2'd0,
    ST_MEASURE  = 2'd1,
    ST_PREDICT  = 2'd2,
    ST_HOLD     = 2'd3
  } pred_state_e;

  localparam int SCREEN_H = 474;
  localparam int NET_X    = 390;
  localparam int PADDLE_X = 770;
  localparam int PADDLE_H = 80;

endpackage

// File: rtl/pong_intercept_calc.sv
// Combinational intercept: ball row one column past the net plus its vertical
// direction -> paddle top that centres the paddle on the impact row.
module pong_intercept_calc #(
  parameter int COORD_W  = 11,
  parameter int POS_W    = 9,
  parameter int NET_X    = pong_pkg::NET_X,
  parameter int PADDLE_X = pong_pkg::PADDLE_X,
  parameter int SCREEN_H = pong_pkg::SCREEN_H,
  parameter int PADDLE_H = pong_pkg::PADDLE_H,
  parameter int MAX_POS  = 395
) (
  input  logic [COORD_W-1:0] v1_i,
  input  logic               dir_down_i,
  output logic [POS_W-1:0]   target_o
);

  localparam int CW = COORD_W + 2;
  localparam logic signed [CW-1:0] DX      = CW'(PADDLE_X - (NET_X + 1));
  localparam logic signed [CW-1:0] BOT     = CW'(SCREEN_H - 1);
  localparam logic signed [CW-1:0] TWO_BOT = CW'(2 * (SCREEN_H - 1));
  localparam logic signed [CW-1:0] HALF_H  = CW'(PADDLE_H / 2);
  localparam logic signed [CW-1:0] MAXP_S  = CW'(MAX_POS);

  logic signed [CW-1:0] v1_s;
  logic signed [CW-1:0] y;
  logic signed [CW-1:0] top;

  // The horizontal run to the paddle is shorter than the screen height, so a
  // single reflection off either wall is all that can occur.
  always_comb begin
    v1_s     = $signed({2'b00, v1_i});
    y        = '0;
    top      = '0;
    target_o = '0;
    if (dir_down_i) begin
      y = v1_s + DX;
      if (y > BOT) y = TWO_BOT - y;
    end else begin
      y = (DX > v1_s) ? (DX - v1_s) : (v1_s - DX);
    end
    top = y - HALF_H;
    if (top[CW-1])        target_o = '0;
    else if (top > MAXP_S) target_o = POS_W'(MAX_POS);
    else                   target_o = top[POS_W-1:0];
  end

endmodule

// File: rtl/pong_ai_predictor.sv
// Computer-player paddle: predicts the ball intercept after it crosses the net
// and slews the paddle toward it one pixel per step period.
module pong_ai_predictor #(
  parameter int COORD_W   = 11,
  parameter int POS_W     = 9,
  parameter int OUT_W     = 8,
  parameter int POS_SHIFT = 1,
  parameter int NET_X     = pong_pkg::NET_X,
  parameter int PADDLE_X  = pong_pkg::PADDLE_X,
  parameter int SCREEN_H  = pong_pkg::SCREEN_H,
  parameter int PADDLE_H  = pong_pkg::PADDLE_H,
  parameter int MAX_POS   = 395,
  parameter int RESET_POS = 240,
  parameter int STEP_DIV  = 12421770
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [1:0]         MODE,
  input  logic [COORD_W-1:0] BALL_H,
  input  logic [COORD_W-1:0] BALL_V,
  output logic [OUT_W-1:0]   POSITION,
  output logic [POS_W-1:0]   TARGET,
  output logic               PREDICT_VALID,
  output logic [1:0]         DBG_STATE
);

  import pong_pkg::*;

  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CW = COORD_W + 2;
  localparam logic [TW-1:0]         TIMER_LAST = TW'(STEP_DIV - 1);
  localparam logic [POS_W-1:0]      MAXP       = POS_W'(MAX_POS);
  localparam logic [POS_W-1:0]      MID_POS    = POS_W'(MAX_POS / 2);
  localparam logic [POS_W-1:0]      RST_POS    = POS_W'(RESET_POS);
  localparam logic [COORD_W-1:0]    NET_H      = COORD_W'(NET_X);
  localparam logic [COORD_W-1:0]    NET_H1     = COORD_W'(NET_X + 1);
  localparam logic signed [CW-1:0]  HALF_H     = CW'(PADDLE_H / 2);
  localparam logic signed [CW-1:0]  MAXP_S     = CW'(MAX_POS);

  pred_state_e        state_q, state_d;
  logic [COORD_W-1:0] v0_q, v0_d, v1_q, v1_d;
  logic               dir_down_q, dir_down_d;
  logic [POS_W-1:0]   target_q, target_d;
  logic               valid_q, valid_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [POS_W-1:0]   paddle_q, paddle_d;
  logic               sweep_up_q, sweep_up_d;

  logic               at_net;
  logic               step;
  logic [POS_W-1:0]   calc_target;
  logic signed [CW-1:0] follow_s;
  logic [POS_W-1:0]   follow_tgt;
  logic [POS_W-1:0]   chase_tgt;

  assign at_net = (BALL_H == NET_H);
  assign step   = (timer_q == '0);

  pong_intercept_calc #(
    .COORD_W (COORD_W),
    .POS_W   (POS_W),
    .NET_X   (NET_X),
    .PADDLE_X(PADDLE_X),
    .SCREEN_H(SCREEN_H),
    .PADDLE_H(PADDLE_H),
    .MAX_POS (MAX_POS)
  ) u_calc (
    .v1_i      (v1_q),
    .dir_down_i(dir_down_q),
    .target_o  (calc_target)
  );

  // PREDICT_VALID is a level, not a handshake: it rises together with TARGET
  // taking a fresh prediction and falls when the ball next reaches the net.
  always_comb begin
    state_d    = state_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    dir_down_d = dir_down_q;
    target_d   = target_q;
    valid_d    = valid_q;
    case (state_q)
      ST_WAIT_NET: begin
        if (at_net) begin
          v0_d    = BALL_V;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (!at_net) begin
          if (BALL_H == NET_H1) begin
            v1_d       = BALL_V;
            dir_down_d = (BALL_V > v0_q);
            state_d    = ST_PREDICT;
          end else begin
            target_d = MID_POS;
            valid_d  = 1'b0;
            state_d  = ST_WAIT_NET;
          end
        end
      end
      ST_PREDICT: begin
        if (at_net) begin
          v0_d    = BALL_V;
          valid_d = 1'b0;
          state_d = ST_MEASURE;
        end else begin
          target_d = calc_target;
          valid_d  = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (at_net) begin
          v0_d    = BALL_V;
          valid_d = 1'b0;
          state_d = ST_MEASURE;
        end
      end
      default: state_d = ST_WAIT_NET;
    endcase
  end

  always_comb begin
    follow_s   = $signed({2'b00, BALL_V}) - HALF_H;
    follow_tgt = '0;
    if (follow_s[CW-1])        follow_tgt = '0;
    else if (follow_s > MAXP_S) follow_tgt = MAXP;
    else                        follow_tgt = follow_s[POS_W-1:0];
    chase_tgt = (mode_e'(MODE) == MODE_FOLLOW) ? follow_tgt : target_q;
  end

  // Chasing compares against the registered TARGET, so a same-cycle update
  // only influences the following step.
  always_comb begin
    timer_d    = (timer_q == TIMER_LAST) ? '0 : timer_q + 1'b1;
    paddle_d   = paddle_q;
    sweep_up_d = sweep_up_q;
    if (step) begin
      case (mode_e'(MODE))
        MODE_SWEEP: begin
          if (sweep_up_q) begin
            if (paddle_q >= MAXP) begin
              sweep_up_d = 1'b0;
              paddle_d   = paddle_q - 1'b1;
            end else begin
              paddle_d = paddle_q + 1'b1;
            end
          end else begin
            if (paddle_q == '0) begin
              sweep_up_d = 1'b1;
              paddle_d   = paddle_q + 1'b1;
            end else begin
              paddle_d = paddle_q - 1'b1;
            end
          end
        end
        MODE_FOLLOW, MODE_PREDICT: begin
          if (paddle_q < chase_tgt)      paddle_d = paddle_q + 1'b1;
          else if (paddle_q > chase_tgt) paddle_d = paddle_q - 1'b1;
        end
        default: paddle_d = paddle_q;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_WAIT_NET;
      v0_q       <= '0;
      v1_q       <= '0;
      dir_down_q <= 1'b0;
      target_q   <= MID_POS;
      valid_q    <= 1'b0;
      timer_q    <= '0;
      paddle_q   <= RST_POS;
      sweep_up_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      dir_down_q <= dir_down_d;
      target_q   <= target_d;
      valid_q    <= valid_d;
      timer_q    <= timer_d;
      paddle_q   <= paddle_d;
      sweep_up_q <= sweep_up_d;
    end
  end

  assign POSITION      = OUT_W'(paddle_q >> POS_SHIFT);
  assign TARGET        = target_q;
  assign PREDICT_VALID = valid_q;
  assign DBG_STATE     = state_q;

endmodule

// File: tb/tb_pong_ai_predictor.sv
// Bench for pong_ai_predictor: directed intercept cases, sweep/hold, reset,
// then randomized net crossings against a behavioural reference model.
module tb_pong_ai_predictor;

  localparam int STEP_DIV = 4;
  localparam int NET_X    = 390;
  localparam int PADDLE_X = 770;
  localparam int SCREEN_H = 474;
  localparam int PADDLE_H = 80;
  localparam int MAX_POS  = 395;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [10:0] ball_h, ball_v;
  logic [7:0]  position;
  logic [8:0]  target;
  logic        predict_valid;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_paddle, m_target, m_valid, m_cycle;
  bit m_sweep_up, m_have_v0, m_pend, m_dn;
  int m_v0, m_v1;

  always #5 clk = ~clk;

  pong_ai_predictor #(.STEP_DIV(STEP_DIV)) dut (
    .CLOCK        (clk),
    .RESET        (rst),
    .MODE         (mode),
    .BALL_H       (ball_h),
    .BALL_V       (ball_v),
    .POSITION     (position),
    .TARGET       (target),
    .PREDICT_VALID(predict_valid),
    .DBG_STATE    (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int clamp_top(input int row);
    int t;
    t = row - PADDLE_H / 2;
    if (t < 0) return 0;
    if (t > MAX_POS) return MAX_POS;
    return t;
  endfunction

  // Ball travels from column NET_X+1 to PADDLE_X; mirror off a wall if needed.
  function automatic int intercept(input int v1, input bit down);
    int dx, y;
    dx = PADDLE_X - (NET_X + 1);
    if (down) begin
      y = v1 + dx;
      if (y > SCREEN_H - 1) y = 2 * (SCREEN_H - 1) - y;
    end else begin
      y = v1 - dx;
      if (y < 0) y = -y;
    end
    return clamp_top(y);
  endfunction

  function automatic int idle_h();
    int h;
    h = $urandom_range(0, 800);
    if (h == NET_X) h = 0;
    return h;
  endfunction

  task automatic model_reset();
    m_paddle = 240; m_target = MAX_POS / 2; m_valid = 0; m_cycle = 0;
    m_sweep_up = 1; m_have_v0 = 0; m_pend = 0; m_dn = 0; m_v0 = 0; m_v1 = 0;
  endtask

  task automatic model_edge(input int md, input int h, input int v);
    int goal;
    if (m_cycle % STEP_DIV == 0) begin
      if (md == 0) begin
        if (m_sweep_up) begin
          if (m_paddle >= MAX_POS) begin m_sweep_up = 0; m_paddle--; end
          else m_paddle++;
        end else begin
          if (m_paddle <= 0) begin m_sweep_up = 1; m_paddle++; end
          else m_paddle--;
        end
      end else if (md == 1 || md == 2) begin
        goal = (md == 1) ? clamp_top(v) : m_target;
        if (m_paddle < goal) m_paddle++;
        else if (m_paddle > goal) m_paddle--;
      end
    end
    m_cycle++;
    if (m_pend) begin
      m_pend = 0;
      if (h == NET_X) begin m_have_v0 = 1; m_v0 = v; m_valid = 0; end
      else begin m_target = intercept(m_v1, m_dn); m_valid = 1; end
    end else if (m_have_v0) begin
      if (h != NET_X) begin
        m_have_v0 = 0;
        if (h == NET_X + 1) begin m_pend = 1; m_v1 = v; m_dn = (v > m_v0); end
        else begin m_target = MAX_POS / 2; m_valid = 0; end
      end
    end else if (h == NET_X) begin
      m_have_v0 = 1; m_v0 = v; m_valid = 0;
    end
  endtask

  task automatic tick(input int md, input int h, input int v);
    mode = 2'(md); ball_h = 11'(h); ball_v = 11'(v);
    @(posedge clk);
    model_edge(md, h, v);
    #1;
    check("position", 32'(position), 32'(m_paddle >> 1));
    check("target", 32'(target), 32'(m_target));
    check("valid", 32'(predict_valid), 32'(m_valid));
  endtask

  task automatic crossing(input int md, input int v0, input int h1, input int v1);
    tick(md, NET_X, v0);
    tick(md, h1, v1);
    tick(md, idle_h(), $urandom_range(0, SCREEN_H - 1));
  endtask

  initial begin
    int top_seen, bot_seen, in_range;
    int md, sel, v0, h1, v1, n;
    rst = 1'b1; mode = 2'd3; ball_h = '0; ball_v = '0;
    model_reset();
    #2;
    check("rst_position", 32'(position), 120);
    check("rst_target", 32'(target), 197);
    check("rst_valid", 32'(predict_valid), 0);
    check("rst_state", 32'(dbg_state), 0);
    @(negedge clk);
    rst = 1'b0;

    // down, no bounce; then slew 150 steps
    crossing(3, 50, NET_X + 1, 51);
    check("down_target", 32'(target), 390);
    check("down_valid", 32'(predict_valid), 1);
    repeat (600) tick(2, idle_h(), $urandom_range(0, SCREEN_H - 1));
    check("down_position", 32'(position), 195);

    crossing(3, 200, NET_X + 1, 201);
    check("bottom_bounce", 32'(target), 326);
    crossing(3, 300, NET_X + 1, 299);
    check("top_bounce", 32'(target), 40);
    crossing(3, 420, NET_X + 1, 419);
    check("up_clamp0", 32'(target), 0);

    // ball moving away
    tick(3, NET_X, 100);
    tick(3, NET_X - 1, 100);
    check("away_target", 32'(target), 197);
    check("away_valid", 32'(predict_valid), 0);
    repeat (800) tick(2, idle_h(), $urandom_range(0, SCREEN_H - 1));
    check("away_position", 32'(position), 98);

    // net sample during the predict cycle wins
    tick(3, NET_X, 60);
    tick(3, NET_X + 1, 61);
    tick(3, NET_X, 70);
    tick(3, NET_X + 1, 65);
    tick(3, 0, 0);
    check("priority_target", 32'(target), 274);

    // asynchronous reset discards an in-flight prediction
    tick(2, NET_X, 123);
    #2 rst = 1'b1;
    #1;
    check("midrst_position", 32'(position), 120);
    check("midrst_target", 32'(target), 197);
    check("midrst_valid", 32'(predict_valid), 0);
    check("midrst_state", 32'(dbg_state), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick(2, NET_X + 1, 124);
    tick(2, 0, 0);
    check("midrst_discard", 32'(target), 197);

    // sweep from a fresh reset position
    #2 rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    top_seen = 0; bot_seen = 0; in_range = 1;
    repeat (2400) begin
      tick(0, idle_h(), $urandom_range(0, SCREEN_H - 1));
      if (position == 8'd197) top_seen = 1;
      if (position == 8'd0) bot_seen = 1;
      if (position > 8'd197) in_range = 0;
    end
    check("sweep_top", 32'(top_seen), 1);
    check("sweep_bottom", 32'(bot_seen), 1);
    check("sweep_range", 32'(in_range), 1);

    repeat (400) tick(3, idle_h(), $urandom_range(0, 2047));

    // randomized crossings, modes and ball rows
    for (int i = 0; i < 300; i++) begin
      md  = $urandom_range(0, 3);
      sel = $urandom_range(0, 3);
      v0  = $urandom_range(0, SCREEN_H - 1);
      h1  = (sel < 2) ? NET_X + 1 : ((sel == 2) ? NET_X - 1 : idle_h());
      v1  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047)
                                        : $urandom_range(0, SCREEN_H - 1);
      tick(md, NET_X, v0);
      tick(md, h1, v1);
      n = $urandom_range(1, 12);
      repeat (n) tick(md, idle_h(), $urandom_range(0, 2047));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
